// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer for a 5-stage CPU: PC and stage-register write-enables, per-stage valid
// tracking, and hazard resolution in the order memory freeze, taken branch, load-use bubble.
module pipe_stage_ctrl #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic             id_load_use,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_valid,
    output logic             idex_valid,
    output logic             exmem_valid,
    output logic             memwb_valid,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic MEM_STALLS = (MEM_WAIT != 0);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             freeze;
    logic             ifid_valid_nx;
    logic             idex_valid_nx;
    logic             exmem_valid_nx;
    logic             memwb_valid_nx;

    // State, counter and valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            stall_cnt   <= '0;
            ifid_valid  <= 1'b0;
            idex_valid  <= 1'b0;
            exmem_valid <= 1'b0;
            memwb_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            stall_cnt   <= cnt_nx;
            ifid_valid  <= ifid_valid_nx;
            idex_valid  <= idex_valid_nx;
            exmem_valid <= exmem_valid_nx;
            memwb_valid <= memwb_valid_nx;
        end
    end

    assign busy = (state == ST_WAIT);

    // Next state, enables and next valids
    always_comb begin
        state_nx       = state;
        cnt_nx         = stall_cnt;
        freeze         = 1'b0;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_valid_nx  = fetch_valid;
        idex_valid_nx  = ifid_valid;
        exmem_valid_nx = idex_valid;
        memwb_valid_nx = exmem_valid;

        case (state)
            ST_RUN: begin
                if (exmem_valid && mem_req && MEM_STALLS) begin
                    freeze   = 1'b1;
                    state_nx = ST_WAIT;
                    cnt_nx   = CNT_W'(MEM_WAIT - 1);
                end
            end
            ST_WAIT: begin
                // Release cycle does not look at mem_req, so the same op is never re-stalled
                if (stall_cnt != '0) begin
                    freeze = 1'b1;
                    cnt_nx = stall_cnt - CNT_W'(1);
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase

        if (freeze) begin
            // Upstream stages hold; a bubble drains into WB so nothing writes back twice
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            idex_en        = 1'b0;
            exmem_en       = 1'b0;
            ifid_valid_nx  = ifid_valid;
            idex_valid_nx  = idex_valid;
            exmem_valid_nx = exmem_valid;
            memwb_valid_nx = 1'b0;
        end else if (ex_branch_taken && idex_valid) begin
            ifid_valid_nx  = 1'b0;
            idex_valid_nx  = 1'b0;
            exmem_valid_nx = 1'b1;
        end else if (id_load_use && ifid_valid && idex_valid) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            ifid_valid_nx  = ifid_valid;
            idex_valid_nx  = 1'b0;
            exmem_valid_nx = 1'b1;
        end

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: one instance with MEM_WAIT=2, one with MEM_WAIT=0,
// both driven by the same stimulus.
module tb_pipe_stage_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             fetch_valid;
    logic             id_load_use;
    logic             ex_branch_taken;
    logic             mem_req;

    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_valid, idex_valid, exmem_valid, memwb_valid;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    logic             pc_en0, ifid_en0, idex_en0, exmem_en0, memwb_en0;
    logic             ifid_valid0, idex_valid0, exmem_valid0, memwb_valid0;
    logic             busy0;
    logic [CNT_W-1:0] stall_cnt0;

    logic [4:0] en;
    logic [3:0] vld;
    logic [4:0] en0;

    int n_cmp;
    int n_err;

    assign en  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign vld = {ifid_valid, idex_valid, exmem_valid, memwb_valid};
    assign en0 = {pc_en0, ifid_en0, idex_en0, exmem_en0, memwb_en0};

    pipe_stage_ctrl #(.MEM_WAIT(2), .CNT_W(CNT_W)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .id_load_use     (id_load_use),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_valid      (ifid_valid),
        .idex_valid      (idex_valid),
        .exmem_valid     (exmem_valid),
        .memwb_valid     (memwb_valid),
        .busy            (busy),
        .stall_cnt       (stall_cnt)
    );

    pipe_stage_ctrl #(.MEM_WAIT(0), .CNT_W(CNT_W)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .id_load_use     (id_load_use),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .pc_en           (pc_en0),
        .ifid_en         (ifid_en0),
        .idex_en         (idex_en0),
        .exmem_en        (exmem_en0),
        .memwb_en        (memwb_en0),
        .ifid_valid      (ifid_valid0),
        .idex_valid      (idex_valid0),
        .exmem_valid     (exmem_valid0),
        .memwb_valid     (memwb_valid0),
        .busy            (busy0),
        .stall_cnt       (stall_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_cmp++;
        if (obs !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
        end
    endtask

    // One rising edge, then settle so registered and combinational outputs are stable
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst             = 1'b1;
        fetch_valid     = 1'b1;
        id_load_use     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;

        // Reset held two cycles
        step();
        step();
        check("rst_en",    32'(en),        32'h00);
        check("rst_vld",   32'(vld),       32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_cnt",   32'(stall_cnt), 32'h0);

        // Fill from empty; hazards against invalid stages are ignored
        rst             = 1'b0;
        id_load_use     = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        check("fill_en_hazard_noop", 32'(en), 32'h1f);
        step();
        id_load_use     = 1'b0;
        ex_branch_taken = 1'b0;
        check("fill_1", 32'(vld), 32'h8);
        step();
        check("fill_2", 32'(vld), 32'hc);
        step();
        check("fill_3", 32'(vld), 32'he);
        step();
        check("fill_4", 32'(vld), 32'hf);
        check("fill_en", 32'(en), 32'h1f);

        // Load-use bubble
        id_load_use = 1'b1;
        #1;
        check("lu_en", 32'(en), 32'h07);
        step();
        id_load_use = 1'b0;
        check("lu_vld", 32'(vld), 32'hb);
        step();
        check("lu_drain1", 32'(vld), 32'hd);
        step();
        step();
        check("lu_refill", 32'(vld), 32'hf);

        // Branch outranks load-use
        ex_branch_taken = 1'b1;
        id_load_use     = 1'b1;
        #1;
        check("br_en", 32'(en), 32'h1f);
        step();
        ex_branch_taken = 1'b0;
        id_load_use     = 1'b0;
        check("br_vld", 32'(vld), 32'h3);
        step();
        check("br_drain1", 32'(vld), 32'h9);
        step();
        step();
        step();
        check("br_refill", 32'(vld), 32'hf);

        // Memory freeze outranks branch; release applies the squash
        mem_req         = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        check("mf_en0",   32'(en),    32'h01);
        check("mf_busy0", 32'(busy),  32'h0);
        check("mw0_en",   32'(en0),   32'h1f);
        step();
        check("mf_busy1", 32'(busy),      32'h1);
        check("mf_cnt1",  32'(stall_cnt), 32'h1);
        check("mf_vld1",  32'(vld),       32'he);
        check("mf_en1",   32'(en),        32'h01);
        check("mw0_busy1", 32'(busy0),    32'h0);
        step();
        check("mf_busy2", 32'(busy),      32'h1);
        check("mf_cnt2",  32'(stall_cnt), 32'h0);
        check("mf_vld2",  32'(vld),       32'he);
        check("mf_rel_en", 32'(en),       32'h1f);
        step();
        mem_req         = 1'b0;
        ex_branch_taken = 1'b0;
        check("mf_busy3", 32'(busy),      32'h0);
        check("mf_cnt3",  32'(stall_cnt), 32'h0);
        check("mf_vld3",  32'(vld),       32'h3);

        // Reset mid-WAIT
        step();
        step();
        step();
        step();
        check("rw_refill", 32'(vld), 32'hf);
        mem_req = 1'b1;
        step();
        check("rw_busy", 32'(busy),      32'h1);
        check("rw_cnt",  32'(stall_cnt), 32'h1);
        rst = 1'b1;
        #1;
        check("rw_rst_en", 32'(en), 32'h00);
        step();
        rst     = 1'b0;
        mem_req = 1'b0;
        check("rw_busy_after", 32'(busy),      32'h0);
        check("rw_cnt_after",  32'(stall_cnt), 32'h0);
        check("rw_vld_after",  32'(vld),       32'h0);
        check("mw0_busy_end",  32'(busy0),     32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
